lsu_seq: RTL and testbench
==========================

# lsu_seq

Sequential load/store unit for the L1 core pipeline, placed between the execute and write-back stages. It accepts one memory or pass-through operation per transaction over a valid/ready handshake. It issues a single aligned request to the data-memory port with lane-shifted store data and byte mask. For loads, it extracts and sign- or zero-extends the returned data before handing the result downstream.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: datapath width, 32 or 64.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: memory address width.
- Clock and reset: one clock, `i_clk`; asynchronous active-low reset, `i_rst_n`.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  upstream operation valid.
- `o_ready`  out  1  LSU can accept an operation.
- `i_op_ld`  in  1  operation is a load.
- `i_op_st`  in  1  operation is a store (neither set: pass-through).
- `i_byt`  in  `` `ARGS_WIDTH ``  size/sign code: `` `RAM_BYT_1_U/_S ``, `` `RAM_BYT_2_U/_S ``, `` `RAM_BYT_4_U/_S ``, `` `RAM_BYT_8_U ``.
- `i_alu_res`  in  DATA_WIDTH  effective address, or pass-through result.
- `i_gpr_rs2_data`  in  DATA_WIDTH  store data, LSB-justified.
- `o_valid`  out  1  result valid to write-back.
- `i_ready`  in  1  write-back accepts the result.
- `o_gpr_wr_data`  out  DATA_WIDTH  load result or pass-through value.
- `o_exc_misalign`  out  1  misaligned-access exception, qualified by `o_valid`.
- `o_mem_req_valid`  out  1  memory request valid.
- `i_mem_req_ready`  in  1  memory accepts the request.
- `o_mem_req_wr`  out  1  1 = write, 0 = read.
- `o_mem_req_addr`  out  ADDR_WIDTH  address with lane-offset bits cleared.
- `o_mem_req_data`  out  DATA_WIDTH  store data shifted to its lane.
- `o_mem_req_mask`  out  DATA_WIDTH/8  byte-enable mask shifted to its lane.
- `i_mem_rsp_valid`  in  1  read data valid.
- `o_mem_rsp_ready`  out  1  LSU accepts read data.
- `i_mem_rsp_data`  in  DATA_WIDTH  full-width read data.

## Operation
- State machine with states IDLE, REQ, RSP and DONE.
- IDLE:
  - `o_ready` = 1.
  - On `i_valid && o_ready`, the operation fields are captured.
  - Pass-through goes to DONE with result = `i_alu_res`.
  - A memory operation goes to REQ.
  - A misaligned access goes to DONE with the exception set, when the trap is configured in.
- REQ:
  - `o_mem_req_valid` = 1.
  - On `i_mem_req_ready`, a store goes to DONE (stores need no response).
  - On `i_mem_req_ready`, a load goes to RSP.
- RSP:
  - `o_mem_rsp_ready` = 1.
  - On `i_mem_rsp_valid`, the extended data is registered and the state goes to DONE.
- DONE:
  - `o_valid` = 1.
  - On `i_ready`, the state goes to IDLE.
- Lane offset: `off` = `i_alu_res[log2(DATA_WIDTH/8)-1:0]`.
- Store lane alignment:
  - Mask = base mask << `off`; base mask is 1, 3, 0xF or all-ones for sizes 1, 2, 4, 8.
  - Data = rs2 << 8·`off`.
- Load extraction: response data >> 8·`off`, truncated to the size, then sign-extended (`_S` codes) or zero-extended (`_U` codes).
- Unknown size code is treated as `` `RAM_BYT_1_U ``.
- When DATA_WIDTH = 32, `` `RAM_BYT_8_U `` is treated as `` `RAM_BYT_4_U ``.
- `o_exc_misalign` is 0 for pass-through, for size 1, and for aligned accesses.

## Timing
- Reset values: state IDLE; all outputs 0 except `o_ready` = 1.
- Latency from acceptance edge:
  - Pass-through: `o_valid` the next cycle.
  - Store: request one cycle after acceptance; `o_valid` one cycle after the request handshake.
  - Load: `o_valid` one cycle after the response handshake.
- All request fields are registered and held stable while `o_mem_req_valid` is high and `i_mem_req_ready` is low.
- `o_gpr_wr_data` and `o_exc_misalign` are held while `o_valid` is high and `i_ready` is low.
- A response arriving in any state other than RSP is ignored.
- Reset mid-transaction returns to IDLE immediately. Any outstanding memory request or response is dropped; the memory side must tolerate this.
- Throughput is one operation in flight. A new operation is accepted only in IDLE, so at least one cycle is lost between operations.

## Configuration
- `` `LSU_MISALIGN_TRAP_EN `` defined:
  - A misaligned load or store (`off` not a multiple of the size) issues no memory request.
  - The unit goes to DONE with `o_exc_misalign` = 1 and `o_gpr_wr_data` = 0.
- `` `LSU_MISALIGN_TRAP_EN `` undefined:
  - `off` is rounded down to a multiple of the size before the mask, data and extraction are computed.
  - `o_exc_misalign` is tied to 0.

## Structure
- Shared config package/header (with the existing `` `RAM_BYT_* `` codes):
  - New signed size codes `` `RAM_BYT_1_S ``, `` `RAM_BYT_2_S `` and `` `RAM_BYT_4_S ``.
  - An `lsu_state_e` enum.
  - The lane-offset width constant.
- One combinational sub-module, `lsu_lane`, maps (size, off, data) to the shifted store data and mask, and maps the response data to the extended load result. The FSM and registers live in `lsu_seq`.

## Test plan
(DATA_WIDTH = 32)
- Byte store: sb of rs2 = 0x000000AB at address 0x8000_0003 -> request addr 0x8000_0000, mask 4'b1000, data 0xAB00_0000, wr = 1; `o_valid` one cycle after the request handshake.
- Signed/unsigned byte load: lb at 0x8000_0002, response 0x12F4_5678 -> result 0xFFFF_FFF4. Same with lbu -> result 0x0000_00F4.
- Misaligned halfword load: lh at 0x8000_0001.
  - With the macro: no request; `o_valid` with `o_exc_misalign` = 1 one cycle after acceptance.
  - Without the macro: mask 4'b0011, and response 0x0000_8001 gives result 0xFFFF_8001.
- Backpressure: hold `i_mem_req_ready` low for 3 cycles, then hold `i_ready` low for 2 cycles -> request fields and then the result stay stable, with no duplicate request.
- Reset in RSP: deassert `i_rst_n` while waiting for the response -> outputs return to their reset values; a later `i_mem_rsp_valid` produces no `o_valid`.
- Pass-through: `i_alu_res` = 0x1234_5678 with neither op set -> no memory request; `o_gpr_wr_data` = 0x1234_5678 one cycle after acceptance.

Source files
------------

// File: rtl/lsu_seq_pkg.sv
// Shared LSU configuration: memory size/sign codes, FSM state type and lane-size helpers.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef RAM_BYT_1_U
`define RAM_BYT_1_U 0
`endif
`ifndef RAM_BYT_2_U
`define RAM_BYT_2_U 1
`endif
`ifndef RAM_BYT_4_U
`define RAM_BYT_4_U 2
`endif
`ifndef RAM_BYT_8_U
`define RAM_BYT_8_U 3
`endif
`ifndef RAM_BYT_1_S
`define RAM_BYT_1_S 4
`endif
`ifndef RAM_BYT_2_S
`define RAM_BYT_2_S 5
`endif
`ifndef RAM_BYT_4_S
`define RAM_BYT_4_S 6
`endif

package lsu_seq_pkg;

  localparam int unsigned ARGS_W = `ARGS_WIDTH;

  localparam logic [ARGS_W-1:0] BYT_1_U = ARGS_W'(`RAM_BYT_1_U);
  localparam logic [ARGS_W-1:0] BYT_2_U = ARGS_W'(`RAM_BYT_2_U);
  localparam logic [ARGS_W-1:0] BYT_4_U = ARGS_W'(`RAM_BYT_4_U);
  localparam logic [ARGS_W-1:0] BYT_8_U = ARGS_W'(`RAM_BYT_8_U);
  localparam logic [ARGS_W-1:0] BYT_1_S = ARGS_W'(`RAM_BYT_1_S);
  localparam logic [ARGS_W-1:0] BYT_2_S = ARGS_W'(`RAM_BYT_2_S);
  localparam logic [ARGS_W-1:0] BYT_4_S = ARGS_W'(`RAM_BYT_4_S);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Number of address bits that select a byte lane within one data word.
  function automatic int unsigned off_width(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

  localparam int unsigned LSU_OFF_W = off_width(`DATA_WIDTH);

  // Access size as log2(bytes); unknown codes fall back to a byte, 8-byte clamps on 32-bit datapaths.
  function automatic logic [1:0] size_log2(input logic [ARGS_W-1:0] byt, input int unsigned dw);
    case (byt)
      BYT_2_U, BYT_2_S: return 2'd1;
      BYT_4_U, BYT_4_S: return 2'd2;
      BYT_8_U:          return (dw > 32) ? 2'd3 : 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

  function automatic logic is_signed_byt(input logic [ARGS_W-1:0] byt);
    return (byt == BYT_1_S) || (byt == BYT_2_S) || (byt == BYT_4_S);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store data/mask shift and load extract/extend.
// Without LSU_MISALIGN_TRAP_EN the lane offset is rounded down to the access size.
module lsu_lane import lsu_seq_pkg::*; #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  localparam int unsigned MASK_W = DATA_WIDTH / 8,
  localparam int unsigned OFF_W = off_width(DATA_WIDTH)
) (
  input  logic [ARGS_W-1:0]     byt,
  input  logic [OFF_W-1:0]      off,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] st_data_sh_c,
  output logic [MASK_W-1:0]     st_mask_c,
  output logic [DATA_WIDTH-1:0] ld_data_c
);

  logic [1:0]            sz;
  logic                  sgn;
  logic [OFF_W-1:0]      off_eff;
  logic [MASK_W-1:0]     base_mask;
  logic [DATA_WIDTH-1:0] rsp_sh;
  logic [DATA_WIDTH-1:0] keep;
  logic [DATA_WIDTH-1:0] sign_sel;
  int unsigned           nbits;

  always_comb begin
    sz  = size_log2(byt, DATA_WIDTH);
    sgn = is_signed_byt(byt);
`ifdef LSU_MISALIGN_TRAP_EN
    off_eff = off;
`else
    off_eff = off & ~OFF_W'((32'd1 << sz) - 32'd1);
`endif
    nbits     = 32'd8 << sz;
    base_mask = MASK_W'((32'd1 << (32'd1 << sz)) - 32'd1);

    st_mask_c    = base_mask << off_eff;
    st_data_sh_c = st_data << {off_eff, 3'b000};

    // Truncate to the access size, then fill the upper bits with the sign when requested.
    rsp_sh    = rsp_data >> {off_eff, 3'b000};
    keep      = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - nbits);
    sign_sel  = DATA_WIDTH'(1) << (nbits - 32'd1);
    ld_data_c = rsp_sh & keep;
    if (sgn && (|(rsp_sh & sign_sel))) begin
      ld_data_c = ld_data_c | ~keep;
    end
  end

endmodule

// File: rtl/lsu_seq.sv
// Sequential load/store unit: one operation in flight, aligned memory request, extended load result.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_seq import lsu_seq_pkg::*; #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  localparam int unsigned MASK_W = DATA_WIDTH / 8,
  localparam int unsigned OFF_W = off_width(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_op_ld,
  input  logic                  i_op_st,
  input  logic [ARGS_W-1:0]     i_byt,
  input  logic [DATA_WIDTH-1:0] i_alu_res,
  input  logic [DATA_WIDTH-1:0] i_gpr_rs2_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_gpr_wr_data,
  output logic                  o_exc_misalign,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_req_wr,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [DATA_WIDTH-1:0] o_mem_req_data,
  output logic [MASK_W-1:0]     o_mem_req_mask,
  input  logic                  i_mem_rsp_valid,
  output logic                  o_mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_data
);

  lsu_state_e            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  exc_q, exc_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_wr_q, req_wr_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic [MASK_W-1:0]     req_mask_q, req_mask_d;
  logic                  rsp_ready_q, rsp_ready_d;
  logic [ARGS_W-1:0]     byt_q, byt_d;
  logic [OFF_W-1:0]      off_q, off_d;

  logic [ARGS_W-1:0]     lane_byt_c;
  logic [OFF_W-1:0]      lane_off_c;
  logic [DATA_WIDTH-1:0] lane_st_data_c;
  logic [MASK_W-1:0]     lane_st_mask_c;
  logic [DATA_WIDTH-1:0] lane_ld_data_c;
  logic [ADDR_WIDTH-1:0] aligned_addr_c;

  // The lane sees the live operation while idle and the captured one afterwards.
  assign lane_byt_c = (state_q == ST_IDLE) ? i_byt : byt_q;
  assign lane_off_c = (state_q == ST_IDLE) ? i_alu_res[OFF_W-1:0] : off_q;
  assign aligned_addr_c = ADDR_WIDTH'(i_alu_res) & ~ADDR_WIDTH'((32'd1 << OFF_W) - 32'd1);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_c;
  assign misalign_c = |(i_alu_res[OFF_W-1:0] &
                        OFF_W'((32'd1 << size_log2(i_byt, DATA_WIDTH)) - 32'd1));
`endif

  lsu_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .byt          (lane_byt_c),
    .off          (lane_off_c),
    .st_data      (i_gpr_rs2_data),
    .rsp_data     (i_mem_rsp_data),
    .st_data_sh_c (lane_st_data_c),
    .st_mask_c    (lane_st_mask_c),
    .ld_data_c    (lane_ld_data_c)
  );

  // Next-state and next-output logic; every output register is loaded from its _d value.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    wr_data_d   = wr_data_q;
    exc_d       = exc_q;
    req_valid_d = req_valid_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_mask_d  = req_mask_q;
    rsp_ready_d = rsp_ready_q;
    byt_d       = byt_q;
    off_d       = off_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          byt_d = i_byt;
          off_d = i_alu_res[OFF_W-1:0];
          exc_d = 1'b0;
          if (!i_op_ld && !i_op_st) begin
            state_d   = ST_DONE;
            valid_d   = 1'b1;
            wr_data_d = i_alu_res;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misalign_c) begin
            state_d   = ST_DONE;
            valid_d   = 1'b1;
            wr_data_d = '0;
            exc_d     = 1'b1;
          end
`endif
          else begin
            state_d     = ST_REQ;
            req_valid_d = 1'b1;
            req_wr_d    = !i_op_ld;
            req_addr_d  = aligned_addr_c;
            req_data_d  = lane_st_data_c;
            req_mask_d  = lane_st_mask_c;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_req_ready) begin
          req_valid_d = 1'b0;
          if (req_wr_q) begin
            state_d   = ST_DONE;
            valid_d   = 1'b1;
            wr_data_d = '0;
          end else begin
            state_d     = ST_RSP;
            rsp_ready_d = 1'b1;
          end
        end
      end
      ST_RSP: begin
        if (i_mem_rsp_valid) begin
          rsp_ready_d = 1'b0;
          state_d     = ST_DONE;
          valid_d     = 1'b1;
          wr_data_d   = lane_ld_data_c;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      wr_data_q   <= '0;
      exc_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_mask_q  <= '0;
      rsp_ready_q <= 1'b0;
      byt_q       <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      wr_data_q   <= wr_data_d;
      exc_q       <= exc_d;
      req_valid_q <= req_valid_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_mask_q  <= req_mask_d;
      rsp_ready_q <= rsp_ready_d;
      byt_q       <= byt_d;
      off_q       <= off_d;
    end
  end

  assign o_ready         = ready_q;
  assign o_valid         = valid_q;
  assign o_gpr_wr_data   = wr_data_q;
  assign o_exc_misalign  = exc_q;
  assign o_mem_req_valid = req_valid_q;
  assign o_mem_req_wr    = req_wr_q;
  assign o_mem_req_addr  = req_addr_q;
  assign o_mem_req_data  = req_data_q;
  assign o_mem_req_mask  = req_mask_q;
  assign o_mem_rsp_ready = rsp_ready_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Directed self-checking bench for lsu_seq on a 32-bit datapath.
module tb_lsu_seq;
  import lsu_seq_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, o_ready, i_op_ld, i_op_st;
  logic [ARGS_W-1:0] i_byt;
  logic [DW-1:0] i_alu_res, i_gpr_rs2_data;
  logic          o_valid, i_ready;
  logic [DW-1:0] o_gpr_wr_data;
  logic          o_exc_misalign;
  logic          o_mem_req_valid, i_mem_req_ready, o_mem_req_wr;
  logic [AW-1:0] o_mem_req_addr;
  logic [DW-1:0] o_mem_req_data;
  logic [MW-1:0] o_mem_req_mask;
  logic          i_mem_rsp_valid, o_mem_rsp_ready;
  logic [DW-1:0] i_mem_rsp_data;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  lsu_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_op_ld         (i_op_ld),
    .i_op_st         (i_op_st),
    .i_byt           (i_byt),
    .i_alu_res       (i_alu_res),
    .i_gpr_rs2_data  (i_gpr_rs2_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_gpr_wr_data   (o_gpr_wr_data),
    .o_exc_misalign  (o_exc_misalign),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_req_wr    (o_mem_req_wr),
    .o_mem_req_addr  (o_mem_req_addr),
    .o_mem_req_data  (o_mem_req_data),
    .o_mem_req_mask  (o_mem_req_mask),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .o_mem_rsp_ready (o_mem_rsp_ready),
    .i_mem_rsp_data  (i_mem_rsp_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single cycle; caller guarantees the unit is idle.
  task automatic issue(input logic ld, input logic st, input logic [ARGS_W-1:0] byt,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rs2);
    i_valid = 1'b1; i_op_ld = ld; i_op_st = st; i_byt = byt;
    i_alu_res = alu; i_gpr_rs2_data = rs2;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vecs++;
    if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    vecs++;
    if ({o_valid, o_mem_req_valid, o_mem_rsp_ready, o_exc_misalign, o_mem_req_wr} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {o_valid, o_mem_req_valid, o_mem_rsp_ready, o_exc_misalign, o_mem_req_wr});
    end
    vecs++;
    if ({o_gpr_wr_data, o_mem_req_addr, o_mem_req_data, o_mem_req_mask} !== '0) begin
      errs++;
      $display("FAIL reset_data: got %h/%h/%h/%h want zeros",
               o_gpr_wr_data, o_mem_req_addr, o_mem_req_data, o_mem_req_mask);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store();
    logic [ARGS_W-1:0] v_byt  [3] = '{BYT_1_U, BYT_2_U, BYT_4_U};
    logic [DW-1:0]     v_addr [3] = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0004};
    logic [DW-1:0]     v_rs2  [3] = '{32'h0000_00AB, 32'h1234_CDEF, 32'h1122_3344};
    logic [AW-1:0]     e_addr [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
    logic [MW-1:0]     e_mask [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [DW-1:0]     e_data [3] = '{32'hAB00_0000, 32'hCDEF_0000, 32'h1122_3344};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, v_byt[i], v_addr[i], v_rs2[i]);
      vecs++;
      if ({o_mem_req_valid, o_mem_req_wr, o_valid, o_ready} !== 4'b1100) begin
        errs++; $display("FAIL st_req_ctrl[%0d]: got %b want 1100", i,
                         {o_mem_req_valid, o_mem_req_wr, o_valid, o_ready});
      end
      vecs++;
      if ({o_mem_req_addr, o_mem_req_mask, o_mem_req_data} !== {e_addr[i], e_mask[i], e_data[i]}) begin
        errs++; $display("FAIL st_req_fields[%0d]: got %h/%b/%h want %h/%b/%h", i,
                         o_mem_req_addr, o_mem_req_mask, o_mem_req_data, e_addr[i], e_mask[i], e_data[i]);
      end
      i_mem_req_ready = 1'b1;
      tick();
      i_mem_req_ready = 1'b0;
      vecs++;
      if ({o_mem_req_valid, o_valid, o_exc_misalign} !== 3'b010) begin
        errs++; $display("FAIL st_done[%0d]: got %b want 010", i, {o_mem_req_valid, o_valid, o_exc_misalign});
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      vecs++;
      if ({o_valid, o_ready} !== 2'b01) begin
        errs++; $display("FAIL st_idle[%0d]: got %b want 01", i, {o_valid, o_ready});
      end
    end
  endtask

  task automatic test_load();
    logic [ARGS_W-1:0] v_byt  [5] = '{BYT_1_S, BYT_1_U, BYT_2_S, BYT_8_U, 3'd7};
    logic [DW-1:0]     v_addr [5] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0002,
                                      32'h8000_0000, 32'h8000_0001};
    logic [DW-1:0]     v_rsp  [5] = '{32'h12F4_5678, 32'h12F4_5678, 32'h8001_1234,
                                      32'hDEAD_BEEF, 32'h0000_9A00};
    logic [DW-1:0]     e_res  [5] = '{32'hFFFF_FFF4, 32'h0000_00F4, 32'hFFFF_8001,
                                      32'hDEAD_BEEF, 32'h0000_009A};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, v_byt[i], v_addr[i], 32'hFFFF_FFFF);
      vecs++;
      if ({o_mem_req_valid, o_mem_req_wr, o_mem_req_addr} !== {2'b10, 32'h8000_0000}) begin
        errs++; $display("FAIL ld_req[%0d]: got %b/%b/%h want 1/0/80000000", i,
                         o_mem_req_valid, o_mem_req_wr, o_mem_req_addr);
      end
      i_mem_req_ready = 1'b1;
      tick();
      i_mem_req_ready = 1'b0;
      vecs++;
      if ({o_mem_req_valid, o_mem_rsp_ready, o_valid} !== 3'b010) begin
        errs++; $display("FAIL ld_wait[%0d]: got %b want 010", i, {o_mem_req_valid, o_mem_rsp_ready, o_valid});
      end
      i_mem_rsp_valid = 1'b1; i_mem_rsp_data = v_rsp[i];
      tick();
      i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
      vecs++;
      if ({o_valid, o_mem_rsp_ready, o_exc_misalign, o_gpr_wr_data} !== {3'b100, e_res[i]}) begin
        errs++; $display("FAIL ld_result[%0d]: got %b%b%b/%h want 100/%h", i,
                         o_valid, o_mem_rsp_ready, o_exc_misalign, o_gpr_wr_data, e_res[i]);
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
    end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, BYT_2_S, 32'h8000_0001, '0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs++;
    if ({o_mem_req_valid, o_valid, o_exc_misalign, o_gpr_wr_data} !== {3'b011, 32'h0}) begin
      errs++; $display("FAIL mis_trap: got %b%b%b/%h want 011/00000000",
                       o_mem_req_valid, o_valid, o_exc_misalign, o_gpr_wr_data);
    end
`else
    vecs++;
    if ({o_mem_req_valid, o_mem_req_addr, o_mem_req_mask} !== {1'b1, 32'h8000_0000, 4'b0011}) begin
      errs++; $display("FAIL mis_req: got %b/%h/%b want 1/80000000/0011",
                       o_mem_req_valid, o_mem_req_addr, o_mem_req_mask);
    end
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h0000_8001;
    tick();
    i_mem_rsp_valid = 1'b0;
    vecs++;
    if ({o_valid, o_exc_misalign, o_gpr_wr_data} !== {2'b10, 32'hFFFF_8001}) begin
      errs++; $display("FAIL mis_result: got %b%b/%h want 10/ffff8001", o_valid, o_exc_misalign, o_gpr_wr_data);
    end
`endif
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    vecs++;
    if ({o_valid, o_ready, o_mem_req_valid} !== 3'b010) begin
      errs++; $display("FAIL mis_idle: got %b want 010", {o_valid, o_ready, o_mem_req_valid});
    end
  endtask

  task automatic test_backpressure();
    issue(1'b1, 1'b0, BYT_4_U, 32'h8000_0008, '0);
    for (int c = 0; c < 4; c++) begin
      vecs++;
      if ({o_mem_req_valid, o_mem_req_wr, o_mem_req_addr} !== {2'b10, 32'h8000_0008}) begin
        errs++; $display("FAIL bp_req_hold[%0d]: got %b/%b/%h want 1/0/80000008", c,
                         o_mem_req_valid, o_mem_req_wr, o_mem_req_addr);
      end
      if (c < 3) tick();
    end
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    tick();
    vecs++;
    if ({o_mem_req_valid, o_mem_rsp_ready, o_valid} !== 3'b010) begin
      errs++; $display("FAIL bp_no_dup: got %b want 010", {o_mem_req_valid, o_mem_rsp_ready, o_valid});
    end
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'hCAFE_F00D;
    tick();
    i_mem_rsp_valid = 1'b0; i_mem_rsp_data = 32'h0BAD_0BAD;
    for (int c = 0; c < 3; c++) begin
      vecs++;
      if ({o_valid, o_mem_req_valid, o_gpr_wr_data} !== {2'b10, 32'hCAFE_F00D}) begin
        errs++; $display("FAIL bp_res_hold[%0d]: got %b%b/%h want 10/cafef00d", c,
                         o_valid, o_mem_req_valid, o_gpr_wr_data);
      end
      if (c < 2) tick();
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    vecs++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errs++; $display("FAIL bp_idle: got %b want 01", {o_valid, o_ready});
    end
  endtask

  task automatic test_reset_rsp();
    issue(1'b1, 1'b0, BYT_4_U, 32'h8000_0010, '0);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    vecs++;
    if (o_mem_rsp_ready !== 1'b1) begin
      errs++; $display("FAIL rr_in_rsp: got %b want 1", o_mem_rsp_ready);
    end
    rst_n = 1'b0;
    #2;
    vecs++;
    if ({o_ready, o_valid, o_mem_req_valid, o_mem_rsp_ready, o_gpr_wr_data} !== {4'b1000, 32'h0}) begin
      errs++; $display("FAIL rr_reset: got %b%b%b%b/%h want 1000/00000000",
                       o_ready, o_valid, o_mem_req_valid, o_mem_rsp_ready, o_gpr_wr_data);
    end
    #1;
    rst_n = 1'b1;
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h5555_AAAA;
    tick();
    i_mem_rsp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vecs++;
      if ({o_valid, o_ready, o_gpr_wr_data} !== {2'b01, 32'h0}) begin
        errs++; $display("FAIL rr_ignored[%0d]: got %b%b/%h want 01/00000000", c, o_valid, o_ready, o_gpr_wr_data);
      end
      tick();
    end
  endtask

  task automatic test_passthrough();
    issue(1'b0, 1'b0, BYT_1_U, 32'h1234_5678, 32'hFFFF_FFFF);
    for (int c = 0; c < 2; c++) begin
      vecs++;
      if ({o_valid, o_ready, o_mem_req_valid, o_exc_misalign, o_gpr_wr_data} !== {4'b1000, 32'h1234_5678}) begin
        errs++; $display("FAIL pt_result[%0d]: got %b/%h want 1000/12345678", c,
                         {o_valid, o_ready, o_mem_req_valid, o_exc_misalign}, o_gpr_wr_data);
      end
      if (c == 0) tick();
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    vecs++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errs++; $display("FAIL pt_idle: got %b want 01", {o_valid, o_ready});
    end
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1; i_op_ld = 1'b0; i_op_st = 1'b0; i_alu_res = 32'hAAAA_0001;
    tick();
    i_alu_res = 32'hBBBB_0002; i_ready = 1'b1;
    vecs++;
    if ({o_valid, o_ready, o_gpr_wr_data} !== {2'b10, 32'hAAAA_0001}) begin
      errs++; $display("FAIL b2b_first: got %b%b/%h want 10/aaaa0001", o_valid, o_ready, o_gpr_wr_data);
    end
    tick();
    vecs++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errs++; $display("FAIL b2b_gap: got %b want 01", {o_valid, o_ready});
    end
    i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    vecs++;
    if ({o_valid, o_gpr_wr_data} !== {1'b1, 32'hBBBB_0002}) begin
      errs++; $display("FAIL b2b_second: got %b/%h want 1/bbbb0002", o_valid, o_gpr_wr_data);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_op_ld = 1'b0; i_op_st = 1'b0; i_byt = '0;
    i_alu_res = '0; i_gpr_rs2_data = '0; i_ready = 1'b0;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_backpressure();
    test_reset_rsp();
    test_passthrough();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
